// File: rtl/muldiv_seq.sv
// Iterative unsigned RV32M multiply/divide controller (MUL, MULHU, DIVU, REMU) driving the shared EXE adder.
// Optional build macro MULDIV_ZERO_BYPASS_EN: multiplies with a zero operand finish without iterating.
module muldiv_seq #(
  parameter int BITS  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [BITS-1:0] rs1,
  input  logic [BITS-1:0] rs2,
  output logic [BITS-1:0] alu_a,
  output logic [1:0]      sel_a,
  output logic [BITS-1:0] alu_b,
  output logic [1:0]      sel_b,
  input  logic [BITS-1:0] add_sum,
  input  logic            add_co,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] result
);

  typedef enum logic [1:0] {IDLE, MUL_IT, DIV_IT, FIN} state_t;

  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;
  localparam logic [1:0] SEL_PASS = 2'b00;
  localparam logic [1:0] SEL_NEG  = 2'b01;
  localparam logic [1:0] SEL_ZERO = 2'b11;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS - 1);

  state_t           state, state_nxt;
  logic [1:0]       op_q;
  logic [BITS-1:0]  m, d, p, q, r;
  logic [CNT_W-1:0] cnt;

  logic             last;
  logic             mul_zero;
  logic             div_ok;
  logic [BITS-1:0]  rem_sh;
  logic [BITS-1:0]  p_it, q_mul_it, r_it, q_div_it;

`ifdef MULDIV_ZERO_BYPASS_EN
  assign mul_zero = (rs1 == '0) || (rs2 == '0);
`else
  assign mul_zero = 1'b0;
`endif

  assign last = (cnt == CNT_LAST);

  // Shift-add multiply: the adder carry becomes the new top bit of P.
  assign p_it     = {add_co, add_sum[BITS-1:1]};
  assign q_mul_it = {add_sum[0], q[BITS-1:1]};

  // Restoring divide: a bit shifted out of R means the trial subtract always fits.
  assign rem_sh   = {r[BITS-2:0], q[BITS-1]};
  assign div_ok   = add_co | r[BITS-1];
  assign r_it     = div_ok ? add_sum : rem_sh;
  assign q_div_it = {q[BITS-2:0], div_ok};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    alu_a     = '0;
    sel_a     = SEL_ZERO;
    alu_b     = '0;
    sel_b     = SEL_ZERO;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (!op[1]) state_nxt = mul_zero ? FIN : MUL_IT;
          else        state_nxt = (rs2 == '0) ? FIN : DIV_IT;
        end
      end
      MUL_IT: begin
        busy  = 1'b1;
        alu_a = p;
        sel_a = SEL_PASS;
        alu_b = m;
        sel_b = q[0] ? SEL_PASS : SEL_ZERO;
        if (last) state_nxt = FIN;
      end
      DIV_IT: begin
        busy  = 1'b1;
        alu_a = rem_sh;
        sel_a = SEL_PASS;
        alu_b = d;
        sel_b = SEL_NEG;
        if (last) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      m      <= '0;
      d      <= '0;
      p      <= '0;
      q      <= '0;
      r      <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            cnt  <= '0;
            if (!op[1]) begin
              m <= rs1;
              q <= rs2;
              p <= '0;
              if (mul_zero) result <= '0;
            end else begin
              d <= rs2;
              q <= rs1;
              r <= '0;
              if (rs2 == '0) result <= (op == OP_DIVU) ? '1 : rs1;
            end
          end
        end
        MUL_IT: begin
          p   <= p_it;
          q   <= q_mul_it;
          cnt <= cnt + CNT_W'(1);
          if (last) result <= (op_q == OP_MULHU) ? p_it : q_mul_it;
        end
        DIV_IT: begin
          r   <= r_it;
          q   <= q_div_it;
          cnt <= cnt + CNT_W'(1);
          if (last) result <= (op_q == OP_REMU) ? r_it : q_div_it;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: models the shared adder and checks results/latency against plain arithmetic.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [31:0] alu_a, alu_b, add_sum, result;
  logic [1:0]  sel_a, sel_b;
  logic        add_co, busy, done;
  logic [32:0] sum_full;

  int total = 0;
  int bad = 0;

`ifdef MULDIV_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  muldiv_seq #(.BITS(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
    .rs1(rs1), .rs2(rs2), .alu_a(alu_a), .sel_a(sel_a), .alu_b(alu_b),
    .sel_b(sel_b), .add_sum(add_sum), .add_co(add_co), .busy(busy),
    .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] gen(input logic [31:0] x, input logic [1:0] s);
    case (s)
      2'b00:   return x;
      2'b01:   return ~x + 32'd1;
      2'b10:   return ~x;
      default: return 32'd0;
    endcase
  endfunction

  always_comb sum_full = {1'b0, gen(alu_a, sel_a)} + {1'b0, gen(alu_b, sel_b)};
  assign add_sum = sum_full[31:0];
  assign add_co  = sum_full[32];

  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    prod = 64'(a) * 64'(b);
    case (o)
      2'b00:   return prod[31:0];
      2'b01:   return prod[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[1] && b == 0) return 1;
    if (!o[1] && BYP && (a == 0 || b == 0)) return 1;
    return 33;
  endfunction

  // Waits one cycle so the FSM is idle, issues one op, returns right after DONE is seen.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int bcnt);
    @(posedge clk); #1;
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    lat = -1; bcnt = 0; res = 'x;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        lat = n;
        res = result;
        break;
      end
    end
  endtask

  task automatic run_check(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res, exp_r;
    int lat, bcnt, exp_l;
    exp_r = ref_res(o, a, b);
    exp_l = ref_lat(o, a, b);
    do_op(o, a, b, res, lat, bcnt);
    total++;
    if (res !== exp_r) begin
      bad++;
      $display("FAIL %s result op=%0d a=%h b=%h got=%h exp=%h", name, o, a, b, res, exp_r);
    end
    total++;
    if (lat != exp_l) begin
      bad++;
      $display("FAIL %s latency op=%0d a=%h b=%h got=%0d exp=%0d", name, o, a, b, lat, exp_l);
    end
    total++;
    if (bcnt != exp_l - 1) begin
      bad++;
      $display("FAIL %s busy_cycles got=%0d exp=%0d", name, bcnt, exp_l - 1);
    end
  endtask

  task automatic test_reset;
    total++;
    if ({busy, done} !== 2'b00 || result !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b result=%h exp 0 0 0", busy, done, result);
    end
    total++;
    if (sel_a !== 2'b11 || sel_b !== 2'b11 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      bad++;
      $display("FAIL reset_alu got sel=%b/%b alu=%h/%h exp 11/11 0/0", sel_a, sel_b, alu_a, alu_b);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    run_check("mul_7x6", 2'b00, 32'd7, 32'd6);
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse got=%b exp=0", done);
    end
    run_check("mulhu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_check("mul_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_check("divu_100_7", 2'b10, 32'd100, 32'd7);
    run_check("remu_100_7", 2'b11, 32'd100, 32'd7);
    run_check("divu_tpath", 2'b10, 32'hFFFF_FFFF, 32'h8000_0001);
    run_check("remu_tpath", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001);
    run_check("divu_by0", 2'b10, 32'h1234, 32'd0);
    run_check("remu_by0", 2'b11, 32'h1234, 32'd0);
    run_check("mul_zero", 2'b01, 32'h0, 32'hDEAD_BEEF);
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = a;
        3:       b = $urandom | 32'h8000_0000;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'd0;
      run_check("random", o, a, b);
    end
  endtask

  task automatic test_flush;
    logic [31:0] prev;
    int dcnt;
    prev = result;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; rs1 = 32'd123; rs2 = 32'd456;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || sel_a !== 2'b11) begin
      bad++;
      $display("FAIL flush_idle got busy=%b done=%b sel_a=%b exp 0 0 11", busy, done, sel_a);
    end
    total++;
    if (result !== prev) begin
      bad++;
      $display("FAIL flush_result got=%h exp=%h", result, prev);
    end
    dcnt = 0;
    repeat (35) begin @(posedge clk); #1; if (done) dcnt++; end
    total++;
    if (dcnt != 0) begin
      bad++;
      $display("FAIL flush_no_done got=%0d exp=0", dcnt);
    end
    // Flush together with start in idle: nothing is accepted.
    start = 1'b1; flush = 1'b1; op = 2'b00; rs1 = 32'd5; rs2 = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    dcnt = 0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_wins got busy=%b exp=0", busy);
    end
    repeat (35) begin @(posedge clk); #1; if (done) dcnt++; end
    total++;
    if (dcnt != 0 || result !== prev) begin
      bad++;
      $display("FAIL flush_wins_done got dones=%0d result=%h exp 0 %h", dcnt, result, prev);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] res;
    lat = -1; res = 'x;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; rs1 = 32'd9; rs2 = 32'd3;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (n == 6) begin
        start = 1'b1; op = 2'b00; rs1 = 32'd77; rs2 = 32'd2;
      end
      if (done) begin
        lat = n;
        res = result;
        break;
      end
    end
    start = 1'b0;
    total++;
    if (res !== 32'd3) begin
      bad++;
      $display("FAIL busy_start_result got=%h exp=%h", res, 32'd3);
    end
    total++;
    if (lat != 33) begin
      bad++;
      $display("FAIL busy_start_latency got=%0d exp=33", lat);
    end
  endtask

  task automatic test_fin;
    logic [31:0] res;
    int lat, bcnt;
    do_op(2'b10, 32'd50, 32'd5, res, lat, bcnt);
    start = 1'b1; op = 2'b00; rs1 = 32'd3; rs2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd10) begin
      bad++;
      $display("FAIL fin_start_ignored got busy=%b done=%b result=%h exp 0 0 0000000a", busy, done, result);
    end
    do_op(2'b11, 32'd50, 32'd7, res, lat, bcnt);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd1) begin
      bad++;
      $display("FAIL fin_flush got busy=%b done=%b result=%h exp 0 0 00000001", busy, done, result);
    end
    run_check("after_fin_flush", 2'b00, 32'd6, 32'd7);
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; rs1 = 32'd1000; rs2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid got busy=%b done=%b result=%h exp 0 0 0", busy, done, result);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_check("mul_0x5", 2'b00, 32'd0, 32'd5);
  endtask

  initial begin
    #2;
    test_reset;
    test_directed;
    test_random;
    test_flush;
    test_back_to_back;
    test_fin;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative controller for unsigned RV32M multiply and divide (MUL, MULHU, DIVU, REMU) in the EXE stage.
- Reuses the shared EXE adder: each cycle it drives two ALU input generators (select codes plus raw operands) and consumes the adder sum and carry.
- Holds the partial-product, remainder and quotient registers.
- Handshakes with the pipeline through START/BUSY/DONE.

Parameters:
- BITS, 32, datapath width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > BITS.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  start request; accepted only in IDLE.
- FLUSH  in  1  synchronous abort from pipeline.
- OP  in  2  operation: 00 MUL, 01 MULHU, 10 DIVU, 11 REMU; sampled with START.
- RS1  in  BITS  multiplicand / dividend; sampled with START.
- RS2  in  BITS  multiplier / divisor; sampled with START.
- ALU_A  out  BITS  raw operand to input generator A.
- SEL_A  out  2  generator A select: 00 pass, 01 two's complement, 10 invert, 11 zero.
- ALU_B  out  BITS  raw operand to input generator B.
- SEL_B  out  2  generator B select, same encoding as SEL_A.
- ADD_SUM  in  BITS  adder sum, same cycle (combinational path).
- ADD_CO  in  1  adder carry-out.
- BUSY  out  1  high while iterating.
- DONE  out  1  one-cycle pulse; RESULT valid.
- RESULT  out  BITS  registered result; held until the next accepted START.

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE; BUSY=0, DONE=0, RESULT=0; all internal registers 0.
- States: IDLE, MUL_IT, DIV_IT, FIN.
- In IDLE and FIN: SEL_A=SEL_B=11, ALU_A=ALU_B=0.
- IDLE, START=1 and FLUSH=0:
  - Latch OP, RS1, RS2; counter := 0.
  - MUL/MULHU: M := RS1, Q := RS2, P := 0; go to MUL_IT.
  - DIVU/REMU, RS2 != 0: D := RS2, Q := RS1, R := 0; go to DIV_IT.
  - DIVU/REMU, RS2 == 0: RESULT := all ones (DIVU) or RS1 (REMU); go to FIN directly (DONE one cycle after START).
- MUL_IT, one cycle per bit, BUSY=1:
  - ALU_A = P, SEL_A = 00.
  - ALU_B = M; SEL_B = 00 if Q[0] else 11.
  - Update: P := {ADD_CO, ADD_SUM[BITS-1:1]}; Q := {ADD_SUM[0], Q[BITS-1:1]}.
- DIV_IT, one cycle per bit, BUSY=1:
  - T := R[BITS-1]; Rs := {R[BITS-2:0], Q[BITS-1]}.
  - ALU_A = Rs, SEL_A = 00; ALU_B = D, SEL_B = 01.
  - ok := ADD_CO | T.
  - R := ok ? ADD_SUM : Rs; Q := {Q[BITS-2:0], ok}.
- Iteration count: counter increments each iteration; after the iteration with counter = BITS-1, go to FIN and load RESULT:
  - MUL → Q; MULHU → P; DIVU → Q; REMU → R.
- FIN: DONE=1, BUSY=0 for exactly one cycle, then IDLE.
  - START in FIN is ignored.
  - Nominal latency: START cycle + BITS iteration cycles + FIN; DONE asserted BITS+1 cycles after the START edge.
- START while BUSY: ignored; the latched operands are not disturbed.
- FLUSH=1 in any state: IDLE next cycle; no DONE; RESULT unchanged.
  - FLUSH wins over a simultaneous START.
  - FLUSH in FIN suppresses nothing already pulsed, but the FSM still returns to IDLE.
- Arithmetic: all unsigned, modulo 2^BITS. The carry from ALU_IN_GEN's two's-complement path is not used; only ADD_CO.
- Reset mid-operation: immediate return to the reset state; the operation is lost.

Optional Feature:
- Macro: MULDIV_ZERO_BYPASS_EN.
- Defined: MUL/MULHU with RS1==0 or RS2==0 goes IDLE→FIN directly with RESULT := 0; DONE one cycle after START, and BUSY never asserts.
- Undefined: zero operands take the full BITS iterations (result still 0).
- Divide-by-zero shortcut is present in both builds.

Test Plan:
- MUL RS1=7, RS2=6 → DONE exactly 33 cycles after START edge, RESULT=0x0000002A; BUSY high for 32 cycles.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → RESULT=0xFFFFFFFE; repeat as MUL → 0x00000001.
- DIVU 100/7 → 0x0000000E; REMU 100/7 → 0x00000002; DIVU 0xFFFFFFFF/0x80000001 → 1; REMU same operands → 0x7FFFFFFE (exercises T path).
- DIVU 0x1234/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x00001234; DONE one cycle after START; BUSY never high.
- Start MUL, assert FLUSH at iteration 10 → no DONE, IDLE next cycle, RESULT keeps previous value; then DIVU 9/3 → 3 with correct latency; START pulsed while BUSY → ignored.
- Deassert RST_N mid DIVU → BUSY=DONE=RESULT=0 immediately; after release, MUL 0×5 → 0 (bypass build: DONE after 1 cycle; otherwise after 33).
